lsu_dmem: RTL
=============

LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 Parameter ADDR_W, default 32: width of the effective address and data_adr_o; legal values are 16 to 32.
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum number of bus-wait cycles before an error; legal values are at least 2.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  1  request strobe, sampled only in IDLE.
REQ-006 req_load  in  1  request is a load.
REQ-007 req_store  in  1  request is a store.
REQ-008 funct3  in  3  access size/sign (RV32I load/store encoding).
REQ-009 base  in  32  reg1 operand.
REQ-010 offset  in  32  immediate operand.
REQ-011 store_data  in  32  reg2 operand.
REQ-012 data_good  in  1  bus acknowledge.
REQ-013 data_bus_i  in  32  bus read data.
REQ-014 data_read  out  1  bus read strobe.
REQ-015 data_write  out  1  bus write strobe.
REQ-016 data_adr_o  out  ADDR_W  word-aligned bus address.
REQ-017 data_bus_o  out  32  bus write data.
REQ-018 data_sel_o  out  4  byte enables.
REQ-019 data_cpu_o  out  32  extended load result.
REQ-020 busy  out  1  high in READ or WRITE.
REQ-021 done  out  1  one-cycle completion pulse.
REQ-022 err  out  1  qualifies done; high for misaligned, illegal, or timeout.

Function
REQ-023 The FSM states shall be IDLE, READ, WRITE and DONE.
REQ-024 Effective address shall be (base+offset) truncated to ADDR_W, with wrap-around and no overflow flag.
REQ-025 IDLE acceptance shall require req_valid plus exactly one of req_load/req_store; req_valid with neither or both set goes to DONE with err=1.
REQ-026 Legal funct3 values: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; any other funct3 goes to DONE with err=1.
REQ-027 Misalignment (half-word with addr[0]=1, word with addr[1:0]!=0) shall go to DONE with err=1 and cause no bus strobe.
REQ-028 A legal request accepted at edge k shall assert its strobe and data_adr_o={addr[ADDR_W-1:2],2'b00} from cycle k+1; address, data and sel shall hold stable until exit.
REQ-029 Store lanes: SB replicates the byte to all 4 lanes with sel=1<<addr[1:0]; SH replicates the half-word with sel=0011 or 1100; SW uses sel=1111.
REQ-030 Loads: byte/half selection by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; data_sel_o is also driven on reads.
REQ-031 In READ/WRITE, data_good at an edge shall drop the strobe next cycle and enter DONE; on reads data_cpu_o is captured at that same edge.
REQ-032 The wait counter shall clear on entry to READ/WRITE; if data_good is still absent after TIMEOUT_CYC cycles, the FSM enters DONE with err=1 and data_cpu_o is unchanged.
REQ-033 data_good arriving on the timeout cycle itself shall be treated as success.
REQ-034 DONE shall last exactly one cycle (done=1) and then return to IDLE; req_valid in DONE is ignored.
REQ-035 data_good outside READ/WRITE shall be ignored.
REQ-036 data_cpu_o shall hold the last successful load value until the next successful load.
REQ-037 Minimum latency: accept at edge k, data_good at edge k+1, done high in cycle k+2.

Reset
REQ-038 Reset shall set state=IDLE, counter=0, and all outputs to 0, including data_cpu_o.
REQ-039 Reset mid-transaction shall drop strobes at that same edge; no done pulse is produced.

Structure
REQ-040 Package lsu_pkg shall hold the state enum, the funct3 constants and the SEL_* byte-enable constants.
REQ-041 The combinational sub-module lsu_align shall perform lane extract/extend and store replicate/sel generation.
REQ-042 Counter width shall be $clog2(TIMEOUT_CYC+1).

Verification
REQ-043 LW: base=1, offset=3, data_bus_i=0xDEADBEEF, data_good 1 cycle after the strobe -> data_adr_o=4, data_read=1 for 1 cycle, data_cpu_o=0xDEADBEEF, done=1, err=0.
REQ-044 LB/LBU: addr=0x102, data_bus_i=0x0080_0000 -> LB gives 0xFFFFFF80, LBU gives 0x00000080.
REQ-045 SH: addr=0x206, store_data=0x1234ABCD -> data_bus_o=0xABCDABCD, sel=1100, data_write held until data_good.
REQ-046 LH at addr 0x101 -> err=1 with done, and data_read never asserted; funct3=011 load -> err=1.
REQ-047 Timeout: TIMEOUT_CYC=4, data_good held 0 -> strobe high exactly 4 cycles, then done=1 and err=1; data_good on cycle 4 -> success.
REQ-048 Reset mid-read: rst high at cycle 2 of READ -> data_read=0, data_cpu_o=0 and no done after the reset edge.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_pkg : shared state encoding, funct3 codes and byte-enable constants
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] SEL_B0  = 4'b0001;
   localparam logic [3:0] SEL_LO  = 4'b0011;
   localparam logic [3:0] SEL_HI  = 4'b1100;
   localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_align : funct3 legality, store lane replication/byte enables, load extend
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        is_store,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic        illegal,
   output logic        misaligned,
   output logic [31:0] wdata,
   output logic [3:0]  sel,
   output logic [31:0] rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr_lo)
         2'd0:    w_byte = load_word[7:0];
         2'd1:    w_byte = load_word[15:8];
         2'd2:    w_byte = load_word[23:16];
         default: w_byte = load_word[31:24];
      endcase
      w_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
   end

   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      wdata      = store_data;
      sel        = SEL_ALL;
      rdata      = load_word;
      case (funct3)
         F3_B, F3_BU: begin
            // unsigned variants exist only for loads
            illegal = is_store && (funct3 == F3_BU);
            sel     = SEL_B0 << addr_lo;
            wdata   = {4{store_data[7:0]}};
            rdata   = (funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
         end
         F3_H, F3_HU: begin
            illegal    = is_store && (funct3 == F3_HU);
            misaligned = addr_lo[0];
            sel        = addr_lo[1] ? SEL_HI : SEL_LO;
            wdata      = {2{store_data[15:0]}};
            rdata      = (funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
         end
         F3_W: begin
            misaligned = (addr_lo != 2'b00);
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_dmem : load/store unit driving a strobe/acknowledge data bus with timeout
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       base,
   input  logic [31:0]       offset,
   input  logic [31:0]       store_data,
   input  logic              data_good,
   input  logic [31:0]       data_bus_i,
   output logic              data_read,
   output logic              data_write,
   output logic [ADDR_W-1:0] data_adr_o,
   output logic [31:0]       data_bus_o,
   output logic [3:0]        data_sel_o,
   output logic [31:0]       data_cpu_o,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int                c_cnt_w = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYC - 1);

   lsu_state_t         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [2:0]         r_f3;
   logic [1:0]         r_lo;
   logic               r_is_load;

   logic [31:0]        w_sum;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_idle;
   logic [2:0]         w_f3;
   logic [1:0]         w_lo;
   logic               w_is_store;
   logic               w_illegal;
   logic               w_misaligned;
   logic [31:0]        w_wdata;
   logic [3:0]         w_sel;
   logic [31:0]        w_rdata;

   assign w_sum  = base + offset;
   assign w_addr = w_sum[ADDR_W-1:0];

   // One aligner serves both request decode (IDLE) and load extraction (READ)
   assign w_idle     = (r_state == ST_IDLE);
   assign w_f3       = w_idle ? funct3       : r_f3;
   assign w_lo       = w_idle ? w_addr[1:0]  : r_lo;
   assign w_is_store = w_idle ? req_store    : !r_is_load;

   lsu_align u_align (
      .funct3     (w_f3),
      .is_store   (w_is_store),
      .addr_lo    (w_lo),
      .store_data (store_data),
      .load_word  (data_bus_i),
      .illegal    (w_illegal),
      .misaligned (w_misaligned),
      .wdata      (w_wdata),
      .sel        (w_sel),
      .rdata      (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_f3       <= '0;
         r_lo       <= '0;
         r_is_load  <= 1'b0;
         data_read  <= 1'b0;
         data_write <= 1'b0;
         data_adr_o <= '0;
         data_bus_o <= '0;
         data_sel_o <= '0;
         data_cpu_o <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  if ((req_load == req_store) || w_illegal || w_misaligned) begin
                     r_state <= ST_DONE;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end else begin
                     r_state    <= req_load ? ST_READ : ST_WRITE;
                     r_cnt      <= '0;
                     r_f3       <= funct3;
                     r_lo       <= w_addr[1:0];
                     r_is_load  <= req_load;
                     data_read  <= req_load;
                     data_write <= req_store;
                     data_adr_o <= {w_addr[ADDR_W-1:2], 2'b00};
                     data_bus_o <= req_store ? w_wdata : '0;
                     data_sel_o <= w_sel;
                     busy       <= 1'b1;
                  end
               end
            end
            ST_READ, ST_WRITE: begin
               // an acknowledge on the final wait cycle still counts as success
               if (data_good || (r_cnt == c_last)) begin
                  r_state    <= ST_DONE;
                  data_read  <= 1'b0;
                  data_write <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  err        <= !data_good;
                  if (data_good && r_is_load) begin
                     data_cpu_o <= w_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               done    <= 1'b0;
               err     <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
